div_share_arbiter: RTL and testbench

- Owns one iterative divide-by-constant unit (restoring, 1 quotient bit per cycle) and shares it between NUM_REQ requesters, e.g. the part-1 and part-2 dial solver lanes.
- Each request carries one rotation magnitude; the block returns quotient (full turns) and remainder (dial step) to the granting requester only.
- Grants are round-robin; at most one division is in flight.
- Replaces per-lane combinational dividers to cut area and timing.

---
 rtl/div_share_arbiter_if.sv | 27 ++
 rtl/div_share_arbiter.sv | 127 ++++++++++++
 tb/tb_div_share_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between the shared divide-by-constant unit and its requesters.
// The arbiter connects through the slave modport and the requesters through the master modport.
interface div_share_arbiter_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 2,
    parameter int GW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ-1:0]       rsp_valid_o;
    logic [NUM_REQ-1:0]       rsp_ready_i;
    logic [WIDTH-1:0]         quotient_o;
    logic [WIDTH-1:0]         remainder_o;
    logic                     busy_o;
    logic [GW-1:0]            grant_id_o;

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, quotient_o, remainder_o, busy_o, grant_id_o
    );

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, quotient_o, remainder_o, busy_o, grant_id_o
    );
endinterface

// File: rtl/div_share_arbiter.sv
// One restoring divide-by-DIVISOR unit (1 quotient bit per cycle) shared round-robin
// between NUM_REQ requesters; the result goes back only to the requester that was granted.
module div_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int DIVISOR = 100,
    parameter int NUM_REQ = 2
) (
    input logic              clk,
    input logic              rst_n,
    div_share_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH:0] DIV_EXT = (WIDTH + 1)'(DIVISOR);

    if (DIVISOR < 1 || longint'(DIVISOR) >= (64'(1) << WIDTH)) begin : g_bad_divisor
        $error("div_share_arbiter: DIVISOR must satisfy 1 <= DIVISOR < 2**WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("div_share_arbiter: NUM_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {IDLE, DIVIDE, RESPOND} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   idx;
    logic            found;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH:0]  rem_q;        // top bit is headroom for the shifted-in dividend bit
    logic [WIDTH-1:0] dq_q;        // dividend shifts out of the top, quotient bits enter at the bottom
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmdr_q;
    logic [WIDTH:0]  rem_shift;
    logic [WIDTH:0]  rem_next;
    logic            q_bit;

    // Round-robin search starting just after the last grant.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = GW'((int'(grant_q) + i) % NUM_REQ);
            if (!found && bus.req_valid_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dq_q[WIDTH-1]};
        q_bit     = (rem_shift >= DIV_EXT);
        rem_next  = q_bit ? (rem_shift - DIV_EXT) : rem_shift;
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    bus.req_ready_o[sel] = 1'b1;
                    state_d              = DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt_q == '0) state_d = RESPOND;
            end
            RESPOND: begin
                bus.rsp_valid_o[grant_q] = 1'b1;
                if (bus.rsp_ready_i[grant_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            quot_q  <= '0;
            rmdr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        dq_q    <= bus.req_data_i[int'(sel)*WIDTH +: WIDTH];
                        grant_q <= sel;
                        rem_q   <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_next;
                    dq_q  <= {dq_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quot_q <= {dq_q[WIDTH-2:0], q_bit};
                        rmdr_q <= rem_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient_o  = quot_q;
    assign bus.remainder_o = rmdr_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.grant_id_o  = grant_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter: hand-computed quotients/remainders for divisor 100,
// arbitration order, response hold, foreign-ready immunity and asynchronous reset.
module tb_div_share_arbiter;
    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 2;

    logic clk;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    div_share_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    div_share_arbiter #(.WIDTH(WIDTH), .DIVISOR(100), .NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE with req_valid_i[k] set; serves one request from requester k.
    task automatic txn(input int k, input logic [15:0] eq, input logic [15:0] er, input int hold,
                       input bit poke, input bit renew, input logic [15:0] nxt, input string tag);
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready_o), 32'(1 << k));
        @(negedge clk);
        if (renew) bus.req_data_i[k*WIDTH +: WIDTH] = nxt;
        else       bus.req_valid_i[k] = 1'b0;
        check({tag, "_grant"}, 32'(bus.grant_id_o), 32'(k));
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        repeat (WIDTH - 1) @(negedge clk);
        check({tag, "_early_rsp"}, 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'(1 << k));
        check({tag, "_q"}, 32'(bus.quotient_o), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder_o), 32'(er));
        if (poke) bus.rsp_ready_i = 2'(~(1 << k));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid_o), 32'(1 << k));
            check({tag, "_hold_q"}, 32'(bus.quotient_o), 32'(eq));
            check({tag, "_hold_r"}, 32'(bus.remainder_o), 32'(er));
        end
        bus.rsp_ready_i = 2'(1 << k);
        @(negedge clk);
        bus.rsp_ready_i = '0;
        check({tag, "_done_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_done_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_done_q"}, 32'(bus.quotient_o), 32'(eq));
    endtask

    task automatic do_reset();
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] tab0 [5] = '{16'd12345, 16'd7, 16'd100, 16'd9999, 16'd30000};
    logic [15:0] q0   [5] = '{16'd123, 16'd0, 16'd1, 16'd99, 16'd300};
    logic [15:0] r0   [5] = '{16'd45, 16'd7, 16'd0, 16'd99, 16'd0};
    logic [15:0] tab1 [5] = '{16'd101, 16'd5000, 16'd65534, 16'd199, 16'd42};
    logic [15:0] q1   [5] = '{16'd1, 16'd50, 16'd655, 16'd1, 16'd0};
    logic [15:0] r1   [5] = '{16'd1, 16'd0, 16'd34, 16'd99, 16'd42};

    initial begin
        bit seen;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = '0;
        rst_n = 1'b0;
        #12;
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_q", 32'(bus.quotient_o), 32'd0);
        check("rst_r", 32'(bus.remainder_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_grant", 32'(bus.grant_id_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester: 250 / 100.
        bus.req_data_i[0 +: WIDTH] = 16'd250;
        bus.req_valid_i[0] = 1'b1;
        txn(0, 16'd2, 16'd50, 0, 1'b0, 1'b0, 16'd0, "t1");

        // Both valid after reset: requester 0 first, then requester 1.
        do_reset();
        bus.req_data_i = {16'd100, 16'd99};
        bus.req_valid_i = 2'b11;
        txn(0, 16'd0, 16'd99, 0, 1'b0, 1'b0, 16'd0, "t2_r0");
        txn(1, 16'd1, 16'd0, 0, 1'b0, 1'b0, 16'd0, "t2_r1");

        // Both continuously valid: grants must alternate 0,1,0,1...
        bus.req_data_i = {tab1[0], tab0[0]};
        bus.req_valid_i = 2'b11;
        for (int j = 0; j < 5; j++) begin
            txn(0, q0[j], r0[j], 0, 1'b0, j < 4, (j < 4) ? tab0[(j + 1) % 5] : 16'd0, "t3_r0");
            txn(1, q1[j], r1[j], 0, 1'b0, j < 4, (j < 4) ? tab1[(j + 1) % 5] : 16'd0, "t3_r1");
        end

        // Arithmetic boundaries and a response held for 7 cycles.
        bus.req_data_i[0 +: WIDTH] = 16'd0;
        bus.req_valid_i[0] = 1'b1;
        txn(0, 16'd0, 16'd0, 0, 1'b0, 1'b0, 16'd0, "t4_zero");
        bus.req_data_i[WIDTH +: WIDTH] = 16'd65535;
        bus.req_valid_i[1] = 1'b1;
        txn(1, 16'd655, 16'd35, 7, 1'b0, 1'b0, 16'd0, "t4_max");

        // Foreign rsp_ready_i asserted while requester 0 holds the response.
        bus.req_data_i[0 +: WIDTH] = 16'd250;
        bus.req_valid_i[0] = 1'b1;
        txn(0, 16'd2, 16'd50, 3, 1'b1, 1'b0, 16'd0, "t5_poke");

        // Asynchronous reset after 8 iterations discards the division.
        bus.req_data_i[0 +: WIDTH] = 16'd4321;
        bus.req_valid_i[0] = 1'b1;
        @(negedge clk);
        bus.req_valid_i[0] = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(bus.busy_o), 32'd0);
        check("t6_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("t6_q", 32'(bus.quotient_o), 32'd0);
        check("t6_r", 32'(bus.remainder_o), 32'd0);
        check("t6_grant", 32'(bus.grant_id_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid_o != '0 || bus.busy_o) seen = 1'b1;
        end
        check("t6_no_rsp", 32'(seen), 32'd0);
        bus.req_data_i[0 +: WIDTH] = 16'd1234;
        bus.req_valid_i[0] = 1'b1;
        txn(0, 16'd12, 16'd34, 0, 1'b0, 1'b0, 16'd0, "t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
